// File: rtl/pwm_fader.sv
// pwm_fader: duty-value ramp generator feeding a PWM core.
// A command steps out_val toward a target once per div+1 cycles and stops exactly on the target.
module pwm_fader #(
   parameter int WIDTH     = 10,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     cmd_target,
   input  logic [WIDTH-1:0]     cmd_step,
   input  logic [DIV_WIDTH-1:0] cmd_div,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   output logic [WIDTH-1:0]     out_val,
   output logic                 busy,
   output logic                 done
);
   typedef enum logic {IDLE, RAMP} state_t;
   state_t               r_state, w_next;
   logic [WIDTH-1:0]     r_out, r_tgt, r_step;
   logic [DIV_WIDTH-1:0] r_div, r_presc;
   logic                 r_ready, r_done;
   logic                 w_accept, w_tick, w_jump, w_arrive;
   logic [WIDTH:0]       w_diff;
   assign w_accept = cmd_valid && r_ready;
   assign w_tick   = (r_state == RAMP) && (r_presc == '0);
   assign w_jump   = (cmd_step == '0) || (cmd_target == r_out);
   // distance is taken one bit wider so the comparison never wraps
   assign w_diff   = (r_tgt > r_out) ? ({1'b0, r_tgt} - {1'b0, r_out}) : ({1'b0, r_out} - {1'b0, r_tgt});
   assign w_arrive = w_diff <= {1'b0, r_step};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = w_accept ? (w_jump ? IDLE : RAMP) : ((w_tick && w_arrive) ? IDLE : r_state);
   end
   always_comb begin
      busy      = r_state == RAMP;
      done      = r_done;
      cmd_ready = r_ready;
      out_val   = r_out;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         r_out   <= '0;
         r_tgt   <= '0;
         r_step  <= '0;
         r_div   <= '0;
         r_presc <= '0;
      end else begin
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         if (w_accept) begin
            r_tgt   <= cmd_target;
            r_step  <= cmd_step;
            r_div   <= cmd_div;
            r_presc <= cmd_div;
            if (w_jump) begin
               r_out  <= cmd_target;
               r_done <= 1'b1;
            end
         end else if (w_tick) begin
            r_presc <= r_div;
            if (w_arrive) begin
               r_out  <= r_tgt;
               r_done <= 1'b1;
            end else begin
               r_out <= (r_tgt > r_out) ? r_out + r_step : r_out - r_step;
            end
         end else if (r_state == RAMP) begin
            r_presc <= r_presc - DIV_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed and random checks of pwm_fader against an absolute-time ramp model.
module tb_pwm_fader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  cmd_target = '0, cmd_step = '0;
   logic [15:0] cmd_div = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready, busy, done;
   logic [9:0]  out_val;
   int          checks = 0, errors = 0;
   int          m_out = 0, m_tgt = 0, m_step = 0, m_div = 0;
   int          m_ramp = 0, m_done = 0, m_ready = 0;
   longint      cyc = 0, m_next = 0;
   int          n_done;

   pwm_fader #(.WIDTH(10), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .cmd_target(cmd_target), .cmd_step(cmd_step),
      .cmd_div(cmd_div), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .out_val(out_val), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_out = 0; m_tgt = 0; m_step = 0; m_div = 0;
      m_ramp = 0; m_done = 0; m_ready = 0;
   endtask

   // one clock: drive inputs, advance the model by the rules, compare all outputs
   task automatic step(input bit v, input int tgt, input int stp, input int dv);
      int d;
      @(negedge clk);
      cmd_valid = v; cmd_target = tgt[9:0]; cmd_step = stp[9:0]; cmd_div = dv[15:0];
      @(posedge clk);
      cyc++;
      if (!rst) begin
         m_done = 0;
         if (v && m_ready) begin
            m_tgt = tgt; m_step = stp; m_div = dv;
            m_next = cyc + dv + 1;
            if (stp == 0 || tgt == m_out) begin
               m_out = tgt; m_done = 1; m_ramp = 0;
            end else m_ramp = 1;
         end else if (m_ramp && cyc == m_next) begin
            d = (m_tgt > m_out) ? m_tgt - m_out : m_out - m_tgt;
            m_next = cyc + m_div + 1;
            if (d <= m_step) begin
               m_out = m_tgt; m_done = 1; m_ramp = 0;
            end else m_out = (m_tgt > m_out) ? m_out + m_step : m_out - m_step;
         end
         m_ready = 1;
      end
      #1;
      chk("out_val", int'(out_val), m_out);
      chk("busy", int'(busy), m_ramp);
      chk("done", int'(done), m_done);
      chk("cmd_ready", int'(cmd_ready), m_ready);
      if (done) n_done++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst_out", int'(out_val), 0);
      chk("rst_ready", int'(cmd_ready), 0);
      step(1, 5, 1, 0);
      step(0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;
      step(0, 0, 0, 0);
      chk("ready_after_release", int'(cmd_ready), 1);
      idle(2);
      // ramp up 0 -> 100 by 30 every 4 cycles
      n_done = 0;
      step(1, 100, 30, 3);
      for (int i = 1; i <= 16; i++) begin
         step(0, 0, 0, 0);
         if (i == 4) chk("up_e4", int'(out_val), 30);
         if (i == 8) chk("up_e8", int'(out_val), 60);
         if (i == 12) chk("up_e12", int'(out_val), 90);
         if (i == 16) chk("up_e16_done", int'(done), 1);
      end
      chk("up_final", int'(out_val), 100);
      chk("up_done_count", n_done, 1);
      // rails: jump to 1023 then descend by 300 each cycle
      step(1, 1023, 0, 0);
      chk("jump_1023", int'(out_val), 1023);
      step(1, 0, 300, 0);
      step(0, 0, 0, 0); chk("down_723", int'(out_val), 723);
      step(0, 0, 0, 0); chk("down_423", int'(out_val), 423);
      step(0, 0, 0, 0); chk("down_123", int'(out_val), 123);
      step(0, 0, 0, 0); chk("down_0", int'(out_val), 0);
      chk("down_done", int'(done), 1);
      idle(2);
      // immediate jump and equal-target command
      step(1, 512, 0, 7);
      chk("jump_512", int'(out_val), 512);
      chk("jump_done", int'(done), 1);
      chk("jump_busy", int'(busy), 0);
      step(0, 0, 0, 0);
      chk("jump_done_pulse", int'(done), 0);
      step(1, 512, 5, 2);
      chk("same_done", int'(done), 1);
      chk("same_val", int'(out_val), 512);
      step(1, 0, 0, 0);
      // preempt on the tick edge that would have produced 90
      step(1, 100, 30, 3);
      idle(11);
      chk("pre_at60", int'(out_val), 60);
      n_done = 0;
      step(1, 20, 10, 1);
      chk("pre_no90", int'(out_val), 60);
      idle(2); chk("pre_50", int'(out_val), 50);
      idle(2); chk("pre_40", int'(out_val), 40);
      idle(2); chk("pre_30", int'(out_val), 30);
      idle(2); chk("pre_20", int'(out_val), 20);
      idle(3);
      chk("pre_done_count", n_done, 1);
      // asynchronous reset mid-ramp
      step(1, 900, 50, 2);
      idle(7);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_out", int'(out_val), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_ready", int'(cmd_ready), 0);
      @(negedge clk) rst = 1'b0;
      idle(6);
      chk("arst_idle_out", int'(out_val), 0);
      // random commands, including preemption and zero steps
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0)
            step(1, int'($urandom_range(0, 1023)),
                 ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 400)),
                 int'($urandom_range(0, 3)));
         else step(0, 0, 0, 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Duty-cycle ramp generator that sits directly upstream of the PWM core and drives its duty-value input.
- Accepts a command of target value, step size and step interval through a valid/ready handshake.
- Moves its output toward the target by the step size once per interval, saturating exactly at the target.
- Used for LED fade-in/fade-out without CPU involvement per step.

Parameters:
- WIDTH, 10, width of duty value; matches the PWM core WIDTH.
- DIV_WIDTH, 16, width of the step-interval prescaler.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cmd_target  input  WIDTH  final duty value
- cmd_step  input  WIDTH  increment applied per tick; 0 = immediate jump
- cmd_div  input  DIV_WIDTH  tick interval = cmd_div+1 clk cycles
- cmd_valid  input  1  command present
- cmd_ready  output  1  command can be accepted
- out_val  output  WIDTH  current duty value; connects to the PWM core duty input
- busy  output  1  ramp in progress
- done  output  1  one-cycle pulse when out_val reaches the target

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, out_val=0, busy=0, done=0.
  - Prescaler=0; latched target/step/div=0; cmd_ready=0 while rst is high.
- cmd_ready is registered: 1 from the first clk edge after rst deasserts, and stays 1 in both states.
  - A new command preempts any ramp in progress.
- Accept happens on an edge where cmd_valid && cmd_ready.
  - Latch target, step and div.
  - Load prescaler with cmd_div.
  - If cmd_step==0 or cmd_target==out_val: out_val<=cmd_target, done=1 next cycle, state=IDLE, busy=0.
  - Otherwise: state=RAMP, busy=1; out_val is unchanged by the accept itself.
- RAMP state:
  - Prescaler decrements each cycle.
  - At prescaler==0 (tick), reload it with the latched div and perform one step.
  - Ticks therefore occur every div+1 cycles; the first tick is div+1 edges after accept.
- Step arithmetic, done at WIDTH+1 bits to avoid wrap:
  - d = |target - out_val|.
  - If d <= step: out_val<=target, done pulses 1 cycle, state=IDLE, busy=0 in the same cycle as done.
  - Else: out_val<=out_val+step if target>out_val, else out_val-step.
  - out_val never overshoots the target and never wraps past 0 or 2^WIDTH-1.
- IDLE state: out_val is held, prescaler idle, done=0.
- Command accepted on the same edge as a tick: the command wins.
  - The tick's step is discarded and the prescaler reloads with the new cmd_div.
  - The new ramp starts from the pre-tick out_val.
- done is never asserted for a preempted ramp, only for the ramp that reaches its target.
- Retargeting mid-ramp starts from the current out_val; direction is recomputed.
- div=0: a step happens every cycle.
- rst asserted mid-ramp: immediately returns all outputs to reset values; the ramp is lost.
- out_val changes at most once per clk, registered with no combinational path from cmd_* to out_val.
  - The downstream PWM core samples its duty value only at period boundaries; that glitch-free behaviour is required downstream.

Test Plan:
- Reset release, no command: out_val=0, busy=0, done=0; cmd_ready=1 one edge after rst falls.
- Ramp up, WIDTH=10: target=100, step=30, div=3 from 0.
  - out_val goes 30, 60, 90, 100 at edges 4, 8, 12, 16 after accept.
  - done pulses once with out_val=100; busy drops the same cycle.
- Ramp down at the rails: from out_val=1023, target=0, step=300, div=0.
  - out_val goes 723, 423, 123, 0 on consecutive cycles with no wrap; done once.
- Immediate jump: step=0, target=512.
  - out_val=512 on the edge after accept, done=1 for one cycle, busy never 1.
  - Repeat with target==out_val, step=5: done pulses, out_val unchanged.
- Preempt: during the up-ramp above at out_val=60, issue target=20, step=10, div=1.
  - out_val goes 50, 40, 30, 20 every 2 cycles.
  - The accept edge coincides with a tick and no 90 appears.
  - Exactly one done pulse, for the second command.
- Async reset mid-ramp: assert rst between clk edges during a ramp.
  - out_val=0 and busy=0 immediately without a clock.
  - After release the block idles until a new command.
